demux16_seq: RTL and testbench

Registered 1-to-16 demultiplexer that routes a single-bit input stream onto a 16-bit output bank, the receive-side counterpart of the 16:1 select-tree multiplexer used in the same datapath. It runs in either addressed mode, where an external 4-bit select picks the lane, or auto mode, where an internal channel counter sweeps lanes 0..15 and reassembles a 16-bit frame. It sits after the serial link that carries the muxed bit, restoring the parallel word.

---
 rtl/demux_pkg.sv | 10 +
 rtl/dec4to16.sv | 18 +
 rtl/demux16_seq.sv | 88 ++++++++
 tb/tb_demux16_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-16 registered demultiplexer.
// Lane count, select width and the last-lane index that closes a frame.
package demux_pkg;

   localparam int N_CH  = 16;
   localparam int SEL_W = 4;

   localparam logic [SEL_W-1:0] LANE_LAST = 4'd15;

endpackage

// File: rtl/dec4to16.sv
// Combinational 4-to-16 one-hot decoder with enable.
// Ports: idx (lane index), en (enable), onehot (lane write strobes).
module dec4to16
   import demux_pkg::*;
(
   input  logic [SEL_W-1:0] idx,
   input  logic             en,
   output logic [N_CH-1:0]  onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/demux16_seq.sv
// Registered 1-to-16 demux: addressed mode (sel) or auto sweep mode
// that reassembles 16-bit frames.
// Ports: clk, rst (async high), din, valid, auto, sel, clear in;
//        y (lane bank), ch (sweep counter), frame, frame_done out.
module demux16_seq #(
   parameter int N_CH  = 16,
   parameter int SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             valid,
   input  logic             auto,
   input  logic [SEL_W-1:0] sel,
   input  logic             clear,
   output logic [N_CH-1:0]  y,
   output logic [SEL_W-1:0] ch,
   output logic [N_CH-1:0]  frame,
   output logic             frame_done
);

   import demux_pkg::*;

   localparam logic [SEL_W-1:0] CH_ONE = {{(SEL_W-1){1'b0}}, 1'b1};

   logic [N_CH-1:0]  y_q, y_d;
   logic [SEL_W-1:0] ch_q, ch_d;
   logic [N_CH-1:0]  frame_q, frame_d;
   logic             frame_done_q, frame_done_d;

   logic [SEL_W-1:0] idx;
   logic             wr_en;
   logic [N_CH-1:0]  lane_we;
   logic             auto_wr;

   assign idx   = auto ? ch_q : sel;
   assign wr_en = valid & ~clear;

   dec4to16 u_dec (
      .idx    (idx),
      .en     (wr_en),
      .onehot (lane_we)
   );

   assign auto_wr = wr_en & auto;

   always_comb begin
      y_d          = (y_q & ~lane_we) | (lane_we & {N_CH{din}});
      ch_d         = ch_q;
      frame_d      = frame_q;
      frame_done_d = 1'b0;

      if (clear) begin
         y_d  = '0;
         ch_d = '0;
      end else if (!auto) begin
         // Holding ch at 0 makes every auto sweep start on lane 0.
         ch_d = '0;
      end else if (auto_wr) begin
         ch_d = ch_q + CH_ONE;
         if (ch_q == LANE_LAST) begin
            // Lanes 14:0 come from the bank, lane 15 from this bit.
            frame_d      = {din, y_q[N_CH-2:0]};
            frame_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q          <= '0;
         ch_q         <= '0;
         frame_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         y_q          <= y_d;
         ch_q         <= ch_d;
         frame_q      <= frame_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign y          = y_q;
   assign ch         = ch_q;
   assign frame      = frame_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux16_seq.sv
// Directed self-checking bench for demux16_seq.
// Each scenario task drives stimulus and checks inline.
module tb_demux16_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        din;
   logic        valid;
   logic        auto;
   logic [3:0]  sel;
   logic        clear;
   logic [15:0] y;
   logic [3:0]  ch;
   logic [15:0] frame;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;

   demux16_seq #(.N_CH(16), .SEL_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .valid      (valid),
      .auto       (auto),
      .sel        (sel),
      .clear      (clear),
      .y          (y),
      .ch         (ch),
      .frame      (frame),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      valid = 1'b0;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; din = 0; valid = 0; auto = 0; sel = 0; clear = 0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({y, ch, frame, frame_done} !== 37'd0) begin
         failures++;
         $display("FAIL reset_state got y=%h ch=%h frame=%h fd=%b exp all 0",
                  y, ch, frame, frame_done);
      end
   endtask

   task automatic test_addressed();
      do_clear();
      auto = 0;
      valid = 1; din = 1; sel = 4'd3;
      tick();
      checks++;
      if (y !== 16'h0008) begin
         failures++;
         $display("FAIL addr_sel3 got %h exp 0008", y);
      end
      sel = 4'd12;
      tick();
      checks++;
      if (y !== 16'h1008) begin
         failures++;
         $display("FAIL addr_sel12 got %h exp 1008", y);
      end
      din = 0; sel = 4'd3;
      tick();
      checks++;
      if (y !== 16'h1000) begin
         failures++;
         $display("FAIL addr_clr3 got %h exp 1000", y);
      end
      valid = 0; din = 1; sel = 4'd5;
      tick();
      checks++;
      if (y !== 16'h1000 || ch !== 4'd0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL addr_hold got y=%h ch=%h fd=%b exp 1000 0 0",
                  y, ch, frame_done);
      end
   endtask

   task automatic test_auto_frame();
      logic [15:0] pat;
      int pulses;
      pat = 16'hA5C3;
      pulses = 0;
      do_clear();
      auto = 1; valid = 1; sel = 4'd9;
      for (int i = 0; i < 16; i++) begin
         din = pat[i];
         tick();
         pulses += int'(frame_done);
         if (i == 14) begin
            checks++;
            if (ch !== 4'd15) begin
               failures++;
               $display("FAIL auto_ch15 got %h exp f", ch);
            end
         end
      end
      checks++;
      if (frame !== 16'hA5C3 || frame_done !== 1'b1 || ch !== 4'd0) begin
         failures++;
         $display("FAIL auto_frame got f=%h fd=%b ch=%h exp a5c3 1 0",
                  frame, frame_done, ch);
      end
      valid = 0;
      tick();
      pulses += int'(frame_done);
      checks++;
      if (pulses != 1 || frame !== 16'hA5C3) begin
         failures++;
         $display("FAIL auto_pulse got pulses=%0d f=%h exp 1 a5c3",
                  pulses, frame);
      end
   endtask

   task automatic test_mode_switch();
      logic [15:0] pat;
      int pulses;
      pat = 16'h0F0F;
      pulses = 0;
      do_clear();
      auto = 1; valid = 1; din = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         pulses += int'(frame_done);
      end
      checks++;
      if (ch !== 4'd5) begin
         failures++;
         $display("FAIL msw_ch5 got %h exp 5", ch);
      end
      auto = 0; valid = 0;
      tick();
      pulses += int'(frame_done);
      checks++;
      if (ch !== 4'd0 || frame !== 16'hA5C3 || pulses != 0) begin
         failures++;
         $display("FAIL msw_abort got ch=%h f=%h p=%0d exp 0 a5c3 0",
                  ch, frame, pulses);
      end
      auto = 1; valid = 1;
      for (int i = 0; i < 16; i++) begin
         din = pat[i];
         tick();
         pulses += int'(frame_done);
      end
      checks++;
      if (frame !== 16'h0F0F || pulses != 1 || frame_done !== 1'b1) begin
         failures++;
         $display("FAIL msw_frame got f=%h p=%0d fd=%b exp 0f0f 1 1",
                  frame, pulses, frame_done);
      end
      valid = 0;
   endtask

   task automatic test_gapped();
      logic [15:0] pat;
      int pulses;
      int bad_hold;
      pat = 16'hA5C3;
      pulses = 0;
      bad_hold = 0;
      do_clear();
      auto = 1;
      for (int i = 0; i < 16; i++) begin
         valid = 1; din = pat[i];
         tick();
         pulses += int'(frame_done);
         valid = 0; din = ~pat[i];
         tick();
         pulses += int'(frame_done);
         if (ch !== 4'((i + 1) % 16)) bad_hold++;
      end
      checks++;
      if (bad_hold != 0) begin
         failures++;
         $display("FAIL gap_ch_hold got %0d bad cycles exp 0", bad_hold);
      end
      checks++;
      if (frame !== 16'hA5C3 || pulses != 1) begin
         failures++;
         $display("FAIL gap_frame got f=%h p=%0d exp a5c3 1", frame, pulses);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pat;
      int pulses;
      pat = {16'hBEEF, 16'h1234};
      pulses = 0;
      do_clear();
      auto = 1; valid = 1;
      for (int i = 0; i < 32; i++) begin
         din = pat[i];
         tick();
         pulses += int'(frame_done);
         if (i == 15) begin
            checks++;
            if (frame !== 16'h1234 || frame_done !== 1'b1) begin
               failures++;
               $display("FAIL b2b_first got f=%h fd=%b exp 1234 1",
                        frame, frame_done);
            end
         end
      end
      checks++;
      if (frame !== 16'hBEEF || frame_done !== 1'b1 || pulses != 2) begin
         failures++;
         $display("FAIL b2b_second got f=%h fd=%b p=%0d exp beef 1 2",
                  frame, frame_done, pulses);
      end
      valid = 0;
      tick();
   endtask

   task automatic test_clear_collision();
      do_clear();
      auto = 1; valid = 1; din = 1;
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if (ch !== 4'd15 || y !== 16'h7FFF) begin
         failures++;
         $display("FAIL clr_setup got ch=%h y=%h exp f 7fff", ch, y);
      end
      clear = 1;
      tick();
      checks++;
      if (frame_done !== 1'b0 || frame !== 16'hBEEF ||
          y !== 16'h0000 || ch !== 4'd0) begin
         failures++;
         $display("FAIL clr_collide got fd=%b f=%h y=%h ch=%h exp 0 beef 0 0",
                  frame_done, frame, y, ch);
      end
      clear = 0; valid = 0;
      tick();
      checks++;
      if (frame_done !== 1'b0 || frame !== 16'hBEEF) begin
         failures++;
         $display("FAIL clr_after got fd=%b f=%h exp 0 beef",
                  frame_done, frame);
      end
   endtask

   task automatic test_async_reset();
      do_clear();
      auto = 0; valid = 1; din = 1;
      for (int i = 0; i < 16; i++) begin
         sel = 4'(i);
         tick();
      end
      auto = 1;
      for (int i = 0; i < 7; i++) tick();
      valid = 0;
      checks++;
      if (y !== 16'hFFFF || ch !== 4'd7 || frame !== 16'hBEEF) begin
         failures++;
         $display("FAIL arst_setup got y=%h ch=%h f=%h exp ffff 7 beef",
                  y, ch, frame);
      end
      #2 rst = 1;
      #1;
      checks++;
      if ({y, ch, frame, frame_done} !== 37'd0) begin
         failures++;
         $display("FAIL arst_immediate got y=%h ch=%h f=%h fd=%b exp 0",
                  y, ch, frame, frame_done);
      end
      tick();
      rst = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_addressed();
      test_auto_frame();
      test_mode_switch();
      test_gapped();
      test_back_to_back();
      test_clear_collision();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
